// File: rtl/sr_alu_arbiter_if.sv
// Bus bundle between the requesters, the ALU arbiter and the shared ALU.
// Requester k packs its op/a/b at [k*W +: W]; the ALU result comes back on alu_res_i.
interface sr_alu_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 32,
    parameter int OPW   = 3
);
    logic [N_REQ-1:0]     req_i;
    logic [N_REQ-1:0]     lock_i;
    logic [N_REQ*OPW-1:0] op_i;
    logic [N_REQ*DW-1:0]  a_i;
    logic [N_REQ*DW-1:0]  b_i;
    logic [N_REQ-1:0]     gnt_o;
    logic [OPW-1:0]       alu_op_o;
    logic [DW-1:0]        alu_a_o;
    logic [DW-1:0]        alu_b_o;
    logic [DW-1:0]        alu_res_i;
    logic [DW-1:0]        res_o;
    logic                 busy_o;
    logic                 hold_ovf_o;

    // Requesters plus the ALU itself, seen from outside the arbiter
    modport master (
        output req_i, lock_i, op_i, a_i, b_i, alu_res_i,
        input  gnt_o, alu_op_o, alu_a_o, alu_b_o, res_o, busy_o, hold_ovf_o
    );

    // The arbiter
    modport slave (
        input  req_i, lock_i, op_i, a_i, b_i, alu_res_i,
        output gnt_o, alu_op_o, alu_a_o, alu_b_o, res_o, busy_o, hold_ovf_o
    );
endinterface

// File: rtl/sr_alu_arbiter.sv
// Shares one ALU between N_REQ requesters (0 = CPU core, 1 = hypotenuse accelerator).
// Registered one-hot grant, optional multi-cycle lock, sticky hold-overflow flag.
// Build option: define ALU_ARB_RR_EN for round-robin priority; otherwise the lowest index wins.
module sr_alu_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DW       = 32,
    parameter int OPW      = 3,
    parameter int MAX_HOLD = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    sr_alu_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);
    localparam bit HOLD_CHK = (MAX_HOLD > 0);

    typedef enum logic {IDLE, OWNED} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d;
    logic [N_REQ-1:0] others, cand;
    logic [IW-1:0]    start, win_idx;
    logic             win_vld, keep, new_grant;
    logic [OPW-1:0]   mux_op;
    logic [DW-1:0]    mux_a, mux_b;

`ifdef ALU_ARB_RR_EN
    logic [IW-1:0]    ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // Returns {valid, index} of the first set candidate, searching upward from start (wrapping)
    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] c, input logic [IW-1:0] s);
        logic [IW:0] r;
        int          idx;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(s) + i) % N_REQ;
            if (c[idx]) r = {1'b1, IW'(idx)};
        end
        return r;
    endfunction

    // Owner keeps the ALU while it holds req and lock; on release it yields to anyone else waiting
    assign keep    = |(gnt_q & bus.req_i & bus.lock_i);
    assign others  = bus.req_i & ~gnt_q;
    assign cand    = (|others) ? others : bus.req_i;
    assign {win_vld, win_idx} = pick(cand, start);
    assign cnt_inc = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;

    // Next grant, hold counter and overflow flag
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d   = OWNED;
                    gnt_d     = N_REQ'(1) << win_idx;
                    cnt_d     = '0;
                    new_grant = 1'b1;
                end
            end
            OWNED: begin
                if (keep) begin
                    cnt_d = cnt_inc;
                    if (HOLD_CHK && (cnt_inc == MAX_C) && (|others)) ovf_d = 1'b1;
                end else if (win_vld) begin
                    gnt_d     = N_REQ'(1) << win_idx;
                    cnt_d     = '0;
                    new_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer moves to the slot after each new owner
    always_comb begin
        ptr_d = ptr_q;
        if (new_grant) ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

    // Arbiter state registers; reset drops any grant immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Route the granted requester's op/operands to the ALU, zeros when nobody owns it
    always_comb begin
        mux_op = '0;
        mux_a  = '0;
        mux_b  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) begin
                mux_op = bus.op_i[k*OPW +: OPW];
                mux_a  = bus.a_i[k*DW +: DW];
                mux_b  = bus.b_i[k*DW +: DW];
            end
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.alu_op_o   = mux_op;
    assign bus.alu_a_o    = mux_a;
    assign bus.alu_b_o    = mux_b;
    assign bus.res_o      = bus.alu_res_i;
    assign bus.busy_o     = |gnt_q;
    assign bus.hold_ovf_o = ovf_q;
endmodule

// File: tb/tb_sr_alu_arbiter.sv
// Self-checking bench for sr_alu_arbiter: directed vector table, hand-written
// lock/overflow/reset/back-to-back sequences and randomized traffic against a reference model.
module tb_sr_alu_arbiter;
    localparam int N        = 2;
    localparam int DW       = 32;
    localparam int OPW      = 3;
    localparam int MAX_HOLD = 8;

    logic clk_i;
    logic rst_n_i;
    int   nCompared;
    int   nMismatched;

    // Reference model state: current owner (-1 = none), owned cycles counted, sticky flag, RR start
    int   owner;
    int   holdCnt;
    bit   ovfM;
    int   rrStart;

    sr_alu_arbiter_if #(.N_REQ(N), .DW(DW), .OPW(OPW)) bus ();

    sr_alu_arbiter #(.N_REQ(N), .DW(DW), .OPW(OPW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  lock;
        logic [N-1:0]  expGnt;
        logic [DW-1:0] expA;
    } vec_t;

    vec_t vecs[12];

    // Simple ALU standing in for the real one
    function automatic logic [DW-1:0] aluRef(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return a * b;
        endcase
    endfunction

    assign bus.alu_res_i = aluRef(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

    // Free-running clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int pickWinner(input logic [N-1:0] pend, input int from);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (from + i) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic modelReset();
        owner   = -1;
        holdCnt = 0;
        ovfM    = 1'b0;
        rrStart = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        logic [N-1:0] r;
        logic [N-1:0] rest;
        logic [N-1:0] pend;
        int           from;
        r    = bus.req_i;
        rest = r;
        if (owner >= 0) rest[owner] = 1'b0;
        if (owner >= 0 && r[owner] && bus.lock_i[owner]) begin
            if (holdCnt < MAX_HOLD) holdCnt++;
            if (MAX_HOLD > 0 && holdCnt == MAX_HOLD && rest != 0) ovfM = 1'b1;
        end else begin
            pend = (owner >= 0 && rest != 0) ? rest : r;
`ifdef ALU_ARB_RR_EN
            from = rrStart;
`else
            from = 0;
`endif
            owner   = pickWinner(pend, from);
            holdCnt = 0;
            if (owner >= 0) rrStart = (owner + 1) % N;
        end
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0]   eg;
        logic [OPW-1:0] eo;
        logic [DW-1:0]  ea;
        logic [DW-1:0]  eb;
        eg = '0;
        eo = '0;
        ea = '0;
        eb = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            eo = bus.op_i[owner*OPW +: OPW];
            ea = bus.a_i[owner*DW +: DW];
            eb = bus.b_i[owner*DW +: DW];
        end
        compare("gnt",    64'(bus.gnt_o),      64'(eg));
        compare("busy",   64'(bus.busy_o),     64'(owner >= 0));
        compare("ovf",    64'(bus.hold_ovf_o), 64'(ovfM));
        compare("aluOp",  64'(bus.alu_op_o),   64'(eo));
        compare("aluA",   64'(bus.alu_a_o),    64'(ea));
        compare("aluB",   64'(bus.alu_b_o),    64'(eb));
        compare("res",    64'(bus.res_o),      64'(aluRef(eo, ea, eb)));
    endtask

    // One clock with the current inputs, then check everything against the model
    task automatic applyStimulus();
        modelStep();
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    task automatic setReq(input logic [N-1:0] r, input logic [N-1:0] l);
        bus.req_i  = r;
        bus.lock_i = l;
    endtask

    // Assert reset now (asynchronously), hold two edges, release just after an edge
    task automatic doReset();
        setReq('0, '0);
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        modelReset();
        checkOutput();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        modelReset();
        rst_n_i    = 1'b0;
        bus.req_i  = '0;
        bus.lock_i = '0;
        bus.op_i   = {3'd2, 3'd0};
        bus.a_i    = {32'd9, 32'd5};
        bus.b_i    = {32'd3, 32'd7};

        // Reset state straight out of power-up
        #1;
        checkOutput();
        doReset();

`ifdef ALU_ARB_RR_EN
        vecs[3] = '{2'b11, 2'b00, 2'b10, 32'd9};
        vecs[4] = '{2'b11, 2'b00, 2'b01, 32'd5};
`else
        vecs[3] = '{2'b11, 2'b00, 2'b01, 32'd5};
        vecs[4] = '{2'b11, 2'b00, 2'b10, 32'd9};
`endif
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 32'd0};
        vecs[1]  = '{2'b01, 2'b00, 2'b01, 32'd5};
        vecs[2]  = '{2'b00, 2'b00, 2'b00, 32'd0};
        vecs[5]  = '{2'b10, 2'b00, 2'b10, 32'd9};
        vecs[6]  = '{2'b00, 2'b00, 2'b00, 32'd0};
        vecs[7]  = '{2'b10, 2'b10, 2'b10, 32'd9};
        vecs[8]  = '{2'b11, 2'b10, 2'b10, 32'd9};
        vecs[9]  = '{2'b11, 2'b00, 2'b01, 32'd5};
        vecs[10] = '{2'b01, 2'b01, 2'b01, 32'd5};
        vecs[11] = '{2'b00, 2'b00, 2'b00, 32'd0};

        for (int v = 0; v < 12; v++) begin
            setReq(vecs[v].req, vecs[v].lock);
            applyStimulus();
            compare($sformatf("vec%0d.gnt", v), 64'(bus.gnt_o), 64'(vecs[v].expGnt));
            compare($sformatf("vec%0d.aluA", v), 64'(bus.alu_a_o), 64'(vecs[v].expA));
        end

        // Locked owner keeps the ALU 20 cycles while req0 waits, then hands over without a bubble
        doReset();
        setReq(2'b10, 2'b10);
        applyStimulus();
        for (int c = 1; c <= 20; c++) begin
            compare("lockGnt", 64'(bus.gnt_o), 64'(2'b10));
            if (c == 3)  setReq(2'b11, 2'b10);
            if (c == 20) setReq(2'b01, 2'b00);
            applyStimulus();
        end
        compare("lockHandover", 64'(bus.gnt_o), 64'(2'b01));
        setReq(2'b00, 2'b00);
        applyStimulus();

        // Overflow: 10 locked cycles with req0 pending; flag is registered at the end of cycle 8
        doReset();
        setReq(2'b10, 2'b10);
        applyStimulus();
        setReq(2'b11, 2'b10);
        for (int m = 1; m <= 10; m++) begin
            compare($sformatf("ovfCycle%0d", m), 64'(bus.hold_ovf_o), 64'(m >= 9));
            if (m == 10) setReq(2'b01, 2'b01);
            applyStimulus();
        end
        compare("ovfSticky", 64'(bus.hold_ovf_o), 64'(1));
        compare("ovfHandover", 64'(bus.gnt_o), 64'(2'b01));

        // Reset in the middle of an ownership clears everything without a clock edge
        #3;
        rst_n_i = 1'b0;
        #1;
        compare("rstGnt",  64'(bus.gnt_o),      64'(0));
        compare("rstAluA", 64'(bus.alu_a_o),    64'(0));
        compare("rstOvf",  64'(bus.hold_ovf_o), 64'(0));
        compare("rstBusy", 64'(bus.busy_o),     64'(0));
        doReset();

        // Back-to-back single transactions from the CPU keep the grant with no idle cycles
        setReq(2'b01, 2'b00);
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            compare("b2bGnt", 64'(bus.gnt_o), 64'(2'b01));
        end
        setReq(2'b00, 2'b00);
        applyStimulus();

        // Randomized traffic, locks biased high so long ownerships and overflows occur
        doReset();
        for (int c = 0; c < 400; c++) begin
            bus.req_i = N'($urandom_range(0, (1 << N) - 1));
            for (int k = 0; k < N; k++) bus.lock_i[k] = ($urandom_range(0, 7) != 0);
            bus.op_i = N*OPW'($urandom);
            for (int k = 0; k < N; k++) begin
                bus.a_i[k*DW +: DW] = $urandom;
                bus.b_i[k*DW +: DW] = $urandom;
            end
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
